whr_inject_ni: RTL and testbench
================================

WHR_INJECT_NI -- requirements
Module: whr_inject_ni

Interface
REQ-001 buffer_size, 8, downstream router input buffer depth in flits; initial credit count.
REQ-002 addr_width, 4, destination address width (router address plus node address).
REQ-003 max_payload_length / min_payload_length, 4 / 1, payload flit count bounds; payload_length_width = clogb(max-min+1) = 2.
REQ-004 flit_data_width, 64, flit payload width; channel_width = 1 + 2 + flit_data_width.
REQ-005 clk  in  1  sole clock; all state updates on its rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 pkt_valid  in  1  header request present.
REQ-008 pkt_dest  in  addr_width  destination address.
REQ-009 pkt_len  in  payload_length_width  payload length code; flit count = code + min_payload_length.
REQ-010 pkt_ready  out  1  header accepted this cycle (combinational).
REQ-011 data_valid  in  1  payload word present.
REQ-012 data_in  in  flit_data_width  payload word.
REQ-013 data_ready  out  1  payload word accepted this cycle (combinational).
REQ-014 channel_out  out  channel_width  bit 0 link active, bit 1 flit valid, bit 2 head, bits 3.. data (MSB-first).
REQ-015 flow_ctrl_in  in  1  one credit returned per asserted cycle.
REQ-016 idle  out  1  IDLE state and credits == buffer_size.
REQ-017 error  out  1  registered one-cycle error pulse.

Function
REQ-018 Credit counter, width clogb(buffer_size+1), SHALL decrement on each flit sent, increment on flow_ctrl_in, hold when both occur in one cycle.
REQ-019 A flit SHALL be sent only when credits > 0; returned credit SHALL NOT be usable in the cycle of its arrival.
REQ-020 FSM states: IDLE, BODY.
REQ-021 IDLE: pkt_ready = pkt_valid && credits>0; on accept, send head flit, load remaining = code + min_payload_length, go to BODY.
REQ-022 Head flit data: bits [0:addr_width-1] = pkt_dest, next payload_length_width bits = pkt_len, remainder zero.
REQ-023 BODY: data_ready = data_valid && credits>0; on accept, send payload flit (head=0, data=data_in), decrement remaining.
REQ-024 Accepting a payload with remaining == 1 SHALL return the FSM to IDLE; the next header SHALL be accepted no earlier than the following cycle.
REQ-025 pkt_ready SHALL be 0 in BODY; data_ready SHALL be 0 in IDLE.
REQ-026 channel_out SHALL be registered: flit accepted in cycle N appears in cycle N+1 with valid=1; valid=0 and data held otherwise.
REQ-027 Link active bit SHALL be registered as (flit sent) OR (state BODY) OR pkt_valid, sampled in the prior cycle.
REQ-028 Credit return while credits == buffer_size SHALL pulse error next cycle and leave the counter saturated.
REQ-029 Upstream stalls (valid low) SHALL insert bubbles without losing state; no timeout.

Reset
REQ-030 Reset SHALL force IDLE, credits = buffer_size, remaining = 0, channel_out = all zero, error = 0.
REQ-031 Reset mid-packet SHALL abandon the packet; no further payload flits; pkt_ready/data_ready = 0 during reset.
REQ-032 flow_ctrl_in SHALL be ignored while reset is asserted.

Verification
REQ-033 pkt_dest=4'hA, pkt_len=2'd1, then two data words continuously valid -> head flit cycle 1 (data MSBs 1010_01), payloads cycles 2-3, idle=0 until 3 credits return.
REQ-034 No credit return, continuous packets of length 4 -> exactly 8 flits sent, then pkt_ready/data_ready held 0; one credit pulse -> exactly one more flit, sent the cycle after the pulse.
REQ-035 Send and credit return in the same cycle at credits=3 -> counter remains 3.
REQ-036 Credit pulse with credits=8 -> error=1 for exactly one cycle, counter stays 8.
REQ-037 Reset asserted after 2 of 4 payload flits -> channel_out=0 next cycle, IDLE, credits=8; next header accepted normally.
REQ-038 data_valid toggling 1,0,1,0 in BODY -> payload flits spaced with valid=0 bubbles, head bit 0, link bit held 1.

Source files
------------

// File: rtl/whr_inject_ni.sv
// Wormhole router injection network interface.
// Turns a header request plus a stream of payload words into head/body flits
// on a registered channel, gated by a credit counter that mirrors the free
// space in the downstream router input buffer.
module whr_inject_ni #(
   parameter int buffer_size        = 8,
   parameter int addr_width         = 4,
   parameter int max_payload_length = 4,
   parameter int min_payload_length = 1,
   parameter int flit_data_width    = 64,
   localparam int payload_length_width = $clog2(max_payload_length - min_payload_length + 1),
   localparam int channel_width        = 1 + 2 + flit_data_width
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic                            pkt_valid,
   input  logic [addr_width-1:0]           pkt_dest,
   input  logic [payload_length_width-1:0] pkt_len,
   output logic                            pkt_ready,
   input  logic                            data_valid,
   input  logic [flit_data_width-1:0]      data_in,
   output logic                            data_ready,
   output logic [channel_width-1:0]        channel_out,
   input  logic                            flow_ctrl_in,
   output logic                            idle,
   output logic                            error
);

   localparam int CREDIT_W = $clog2(buffer_size + 1);
   localparam int REMAIN_W = $clog2(max_payload_length + 1);

   localparam logic [CREDIT_W-1:0] CREDIT_MAX = CREDIT_W'(buffer_size);
   localparam logic [REMAIN_W-1:0] LEN_BIAS   = REMAIN_W'(min_payload_length);
   localparam logic [REMAIN_W-1:0] LAST_FLIT  = REMAIN_W'(1);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_BODY = 1'b1
   } state_t;

   state_t                     state_q, state_d;
   logic [CREDIT_W-1:0]        credit_q, credit_d;
   logic [REMAIN_W-1:0]        remain_q, remain_d;
   logic [channel_width-1:0]   chan_q, chan_d;
   logic                       error_q, error_d;

   logic                       have_credit;
   logic                       flit_send;
   logic [flit_data_width-1:0] head_data;

   // A credit returned this cycle only becomes usable once it is registered.
   assign have_credit = (credit_q != '0);
   assign flit_send   = pkt_ready | data_ready;

   // Head flit payload: destination in the top bits, then the length code, rest zero.
   always_comb begin
      head_data = '0;
      head_data[flit_data_width-1 -: addr_width] = pkt_dest;
      head_data[flit_data_width-addr_width-1 -: payload_length_width] = pkt_len;
   end

   // Packet FSM: handshakes, next state and remaining payload count.
   always_comb begin
      state_d    = state_q;
      remain_d   = remain_q;
      pkt_ready  = 1'b0;
      data_ready = 1'b0;
      case (state_q)
         ST_IDLE: begin
            pkt_ready = pkt_valid & have_credit & ~reset;
            if (pkt_ready) begin
               state_d  = ST_BODY;
               remain_d = REMAIN_W'(pkt_len) + LEN_BIAS;
            end
         end
         ST_BODY: begin
            data_ready = data_valid & have_credit & ~reset;
            if (data_ready) begin
               remain_d = remain_q - 1'b1;
               if (remain_q == LAST_FLIT) begin
                  state_d = ST_IDLE;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Credit bookkeeping; a return into a full counter is flagged, not counted.
   always_comb begin
      credit_d = credit_q;
      error_d  = 1'b0;
      case ({flit_send, flow_ctrl_in})
         2'b10: credit_d = credit_q - 1'b1;
         2'b01: begin
            if (credit_q == CREDIT_MAX) begin
               error_d = 1'b1;
            end else begin
               credit_d = credit_q + 1'b1;
            end
         end
         default: credit_d = credit_q;
      endcase
   end

   // Next channel word: new flit when one is accepted, otherwise hold the data with valid low.
   always_comb begin
      chan_d    = chan_q;
      chan_d[0] = flit_send | (state_q == ST_BODY) | pkt_valid;
      chan_d[1] = 1'b0;
      chan_d[2] = 1'b0;
      if (pkt_ready) begin
         chan_d[1] = 1'b1;
         chan_d[2] = 1'b1;
         chan_d[channel_width-1:3] = head_data;
      end else if (data_ready) begin
         chan_d[1] = 1'b1;
         chan_d[channel_width-1:3] = data_in;
      end
   end

   // State registers; reset abandons any packet in flight and refills credits.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         credit_q <= CREDIT_MAX;
         remain_q <= '0;
         chan_q   <= '0;
         error_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         credit_q <= credit_d;
         remain_q <= remain_d;
         chan_q   <= chan_d;
         error_q  <= error_d;
      end
   end

   assign channel_out = chan_q;
   assign error       = error_q;
   assign idle        = (state_q == ST_IDLE) && (credit_q == CREDIT_MAX);

endmodule

// File: tb/tb_whr_inject_ni.sv
// Bench for whr_inject_ni: directed packets, expected flits queued at issue
// and popped by a monitor whenever the channel shows a valid flit.
`timescale 1ns/1ps
module tb_whr_inject_ni;

   logic        clk = 1'b0;
   logic        reset;
   logic        pkt_valid;
   logic [3:0]  pkt_dest;
   logic [1:0]  pkt_len;
   logic        pkt_ready;
   logic        data_valid;
   logic [63:0] data_in;
   logic        data_ready;
   logic [66:0] channel_out;
   logic        flow_ctrl_in;
   logic        idle;
   logic        error;

   typedef struct packed {
      logic        head;
      logic [63:0] data;
   } flit_t;

   flit_t exp_q[$];
   int    total = 0;
   int    bad   = 0;

   always #5 clk = ~clk;

   whr_inject_ni dut (
      .clk          (clk),
      .reset        (reset),
      .pkt_valid    (pkt_valid),
      .pkt_dest     (pkt_dest),
      .pkt_len      (pkt_len),
      .pkt_ready    (pkt_ready),
      .data_valid   (data_valid),
      .data_in      (data_in),
      .data_ready   (data_ready),
      .channel_out  (channel_out),
      .flow_ctrl_in (flow_ctrl_in),
      .idle         (idle),
      .error        (error)
   );

   task automatic chkw(input string nm, input logic [66:0] act, input logic [66:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic monitor();
      flit_t e;
      forever begin
         @(negedge clk);
         if (channel_out[1] === 1'b1) begin
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_flit: got %0h expected none", channel_out);
            end else begin
               e = exp_q.pop_front();
               chkw("flit_data", 67'(channel_out[66:3]), 67'(e.data));
               chkw("flit_head", 67'(channel_out[2]), 67'(e.head));
               chkw("flit_link", 67'(channel_out[0]), 67'(1));
            end
         end
      end
   endtask

   task automatic send_head(input logic [3:0] d, input logic [1:0] l);
      flit_t f;
      pkt_dest  = d;
      pkt_len   = l;
      pkt_valid = 1'b1;
      #1;
      chkw("pkt_ready", 67'(pkt_ready), 67'(1));
      f = {1'b1, d, l, 58'd0};
      exp_q.push_back(f);
      @(posedge clk);
      #1;
      pkt_valid = 1'b0;
   endtask

   task automatic send_data(input logic [63:0] d);
      flit_t f;
      data_in    = d;
      data_valid = 1'b1;
      #1;
      chkw("data_ready", 67'(data_ready), 67'(1));
      f = {1'b0, d};
      exp_q.push_back(f);
      @(posedge clk);
      #1;
      data_valid = 1'b0;
   endtask

   task automatic ret(input int n);
      flow_ctrl_in = 1'b1;
      repeat (n) tick();
      flow_ctrl_in = 1'b0;
   endtask

   initial begin
      logic [6:0]  pat;
      logic [63:0] last;
      flit_t       f;

      reset        = 1'b1;
      pkt_valid    = 1'b1;
      pkt_dest     = 4'h0;
      pkt_len      = 2'd0;
      data_valid   = 1'b1;
      data_in      = 64'd0;
      flow_ctrl_in = 1'b1;
      fork
         monitor();
      join_none

      // reset state, handshakes held low while reset is asserted
      repeat (2) @(posedge clk);
      #1;
      chkw("rst_pkt_ready", 67'(pkt_ready), 67'(0));
      chkw("rst_data_ready", 67'(data_ready), 67'(0));
      chkw("rst_channel", channel_out, 67'(0));
      chkw("rst_idle", 67'(idle), 67'(1));
      chkw("rst_error", 67'(error), 67'(0));
      chkw("rst_credit", 67'(dut.credit_q), 67'(8));
      reset        = 1'b0;
      pkt_valid    = 1'b0;
      data_valid   = 1'b0;
      flow_ctrl_in = 1'b0;
      tick();

      // basic packet: dest A, code 1 -> two payloads
      send_head(4'hA, 2'd1);
      pkt_valid = 1'b1;
      #1;
      chkw("body_pkt_ready", 67'(pkt_ready), 67'(0));
      pkt_valid = 1'b0;
      send_data(64'h1111_2222_3333_4444);
      send_data(64'h5555_6666_7777_8888);
      data_valid = 1'b1;
      #1;
      chkw("idle_data_ready", 67'(data_ready), 67'(0));
      data_valid = 1'b0;
      chkw("idle_low_credits", 67'(idle), 67'(0));
      ret(2);
      chkw("idle_two_returned", 67'(idle), 67'(0));
      ret(1);
      chkw("idle_three_returned", 67'(idle), 67'(1));

      // credit exhaustion with back-to-back length-4 packets
      send_head(4'h5, 2'd3);
      for (int i = 0; i < 4; i++) send_data(64'hA000 + 64'(i));
      send_head(4'h6, 2'd3);
      for (int i = 0; i < 2; i++) send_data(64'hB000 + 64'(i));
      chkw("exhaust_credit", 67'(dut.credit_q), 67'(0));
      data_valid = 1'b1;
      data_in    = 64'hB002;
      for (int i = 0; i < 3; i++) begin
         #1;
         chkw("stall_data_ready", 67'(data_ready), 67'(0));
         tick();
      end
      flow_ctrl_in = 1'b1;
      #1;
      chkw("arrival_data_ready", 67'(data_ready), 67'(0));
      tick();
      flow_ctrl_in = 1'b0;
      chkw("arrival_no_flit", 67'(channel_out[1]), 67'(0));
      #1;
      chkw("resume_data_ready", 67'(data_ready), 67'(1));
      f = {1'b0, 64'hB002};
      exp_q.push_back(f);
      tick();
      chkw("resume_flit_valid", 67'(channel_out[1]), 67'(1));
      #1;
      chkw("reexhaust_data_ready", 67'(data_ready), 67'(0));
      data_valid = 1'b0;
      ret(8);
      send_data(64'hB003);
      pkt_valid = 1'b1;
      #1;
      chkw("after_last_pkt_ready", 67'(pkt_ready), 67'(1));
      pkt_valid = 1'b0;
      ret(1);
      chkw("exhaust_idle", 67'(idle), 67'(1));

      // send and return in the same cycle at credits = 3
      send_head(4'h1, 2'd3);
      for (int i = 0; i < 4; i++) send_data(64'hC000 + 64'(i));
      chkw("credit_at_3", 67'(dut.credit_q), 67'(3));
      flow_ctrl_in = 1'b1;
      send_head(4'h2, 2'd0);
      flow_ctrl_in = 1'b0;
      chkw("credit_hold_3", 67'(dut.credit_q), 67'(3));
      send_data(64'hC0DE);
      ret(6);
      chkw("hold_idle", 67'(idle), 67'(1));

      // credit return into a full counter
      chkw("pre_error", 67'(error), 67'(0));
      flow_ctrl_in = 1'b1;
      tick();
      flow_ctrl_in = 1'b0;
      chkw("overflow_error", 67'(error), 67'(1));
      chkw("overflow_credit", 67'(dut.credit_q), 67'(8));
      tick();
      chkw("error_one_cycle", 67'(error), 67'(0));
      chkw("overflow_credit_after", 67'(dut.credit_q), 67'(8));

      // reset after two of four payloads
      send_head(4'h3, 2'd3);
      send_data(64'hD000);
      send_data(64'hD001);
      reset        = 1'b1;
      data_valid   = 1'b1;
      pkt_valid    = 1'b1;
      flow_ctrl_in = 1'b1;
      data_in      = 64'hD002;
      #1;
      chkw("midrst_data_ready", 67'(data_ready), 67'(0));
      chkw("midrst_pkt_ready", 67'(pkt_ready), 67'(0));
      tick();
      chkw("midrst_channel", channel_out, 67'(0));
      chkw("midrst_idle", 67'(idle), 67'(1));
      chkw("midrst_credit", 67'(dut.credit_q), 67'(8));
      reset        = 1'b0;
      data_valid   = 1'b0;
      pkt_valid    = 1'b0;
      flow_ctrl_in = 1'b0;
      tick();
      chkw("postrst_error", 67'(error), 67'(0));
      chkw("postrst_no_flit", 67'(channel_out[1]), 67'(0));
      send_head(4'h7, 2'd0);
      send_data(64'hD0D0);
      ret(2);
      chkw("postrst_idle", 67'(idle), 67'(1));

      // payload stream with bubbles
      send_head(4'h9, 2'd3);
      pat  = 7'b1010101;
      last = 64'd0;
      for (int i = 0; i < 7; i++) begin
         data_valid = pat[i];
         data_in    = 64'hE000 + 64'(i);
         #1;
         chkw("bubble_data_ready", 67'(data_ready), 67'(pat[i]));
         if (pat[i]) begin
            f = {1'b0, data_in};
            exp_q.push_back(f);
            last = data_in;
         end
         tick();
         chkw("bubble_valid", 67'(channel_out[1]), 67'(pat[i]));
         chkw("bubble_link", 67'(channel_out[0]), 67'(1));
         if (!pat[i]) chkw("bubble_data_hold", 67'(channel_out[66:3]), 67'(last));
      end
      data_valid = 1'b0;
      ret(5);
      chkw("bubble_idle", 67'(idle), 67'(1));

      repeat (2) tick();
      chkw("scoreboard_empty", 67'(exp_q.size()), 67'(0));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
